alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Shares one 32-bit combinational ALU between two requesters (req0, req1), for example an integer-issue path and a multi-cycle helper.
- Arbitration is round-robin, one operation accepted per cycle.
- The ALU result is registered into a one-entry output slot tagged with the requester ID.
- Valid/ready handshakes on both request ports and on the response port give full-throughput, backpressure-safe access to the ALU.

Parameters:
- WIDTH, 32, operand/result width; must stay 32 to match the ALU.
- OPW, 3, opcode width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle (valid & ready)
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B / shift amount
- req0_op  input  OPW  opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as req0 for requester 1
- rsp_valid  output  1  output slot holds a result
- rsp_ready  input  1  consumer takes result this cycle
- rsp_id  output  1  requester that issued the result
- rsp_data  output  WIDTH  ALU result
- rsp_err  output  1  opcode was illegal

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset state: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, priority pointer prio=0 (req0 favoured). Ready outputs are combinational and are 0 during reset.
- Slot free: slot_free = !rsp_valid | rsp_ready. A same-cycle drain and refill is allowed, so sustained throughput is 1 op/cycle.
- Grant (combinational):
  - Only reqN_valid: grant N.
  - Both valid: grant prio.
  - Neither valid: no grant.
  - reqN_ready = slot_free & grant==N & !reset. Never both ready in the same cycle.
- On accept: the next edge loads rsp_data, rsp_id=N, rsp_err, rsp_valid=1, and sets prio = !N.
- Latency: exactly 1 cycle, request accept to rsp_valid.
- prio holds when there is no accept. prio also updates when only one requester is valid, so a just-served requester loses the next tie.
- No accept while rsp_valid & rsp_ready: rsp_valid falls to 0; data/id/err hold their last values.
- Stall: while rsp_valid & !rsp_ready, all outputs hold stable and both readies are 0.
- Opcodes (unsigned, 32-bit wrap):
  - 000 add, 001 sub, 010 and, 011 or, 100 logical shift right A by full B, 101 arithmetic shift right A by full B.
  - B >= 32: op 100 gives 0; op 101 gives all bits equal to A[31].
- Illegal ops 110/111: accepted normally. The ALU sees op 000 (masked), rsp_data=0, rsp_err=1. There is no latch/hold behaviour.
- Requesters must keep a, b, op stable while valid & !ready. The block does not check this.
- Reset mid-operation: a pending result is discarded (rsp_valid=0) and prio returns to 0. Requests presented in the reset cycle are not accepted.

Decomposition:
- Shared package `alu_pkg`:
  - opcode localparams ALU_ADD=3'b000, ALU_SUB, ALU_AND, ALU_OR, ALU_SRL, ALU_SRA.
  - ALU_ILLEGAL_MASK.
  - requester ID constants REQ0=1'b0, REQ1=1'b1.
- One sub-module: the existing combinational `alu` (A, B, ALUOp -> C), instantiated once. This block owns the operand mux, op masking, arbiter and output register.

Test Plan:
- Reset, then req0 only: a=5, b=3, op=000 -> req0_ready=1 in cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_data=8, rsp_err=0.
- Both valid every cycle, rsp_ready=1, req0 add 1+1, req1 sub 1-2:
  - grants alternate 0,1,0,1;
  - results 2 and 0xFFFFFFFF alternate;
  - 1 result/cycle with no bubbles.
- Backpressure:
  - Result pending and rsp_ready=0 for 3 cycles -> both readies 0, rsp_data and rsp_id stable.
  - rsp_ready=1 with req1 valid -> drain and accept in the same cycle; new result on the next edge.
- Shifts:
  - a=0x80000000, b=4, op=101 -> 0xF8000000.
  - Same with op=100 -> 0x08000000.
  - b=40, op=101 -> 0xFFFFFFFF.
  - b=40, op=100 -> 0.
- Illegal op 111, a=7, b=9 -> accepted, rsp_data=0, rsp_err=1. The next legal op (or 0xF0, 0x0F) -> 0xFF, rsp_err=0.
- Reset asserted while rsp_valid=1 and both requesters valid -> next cycle rsp_valid=0, no ready asserted; after release, the first tie is granted to req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, illegal-op and requester-ID definitions for the shared ALU block.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  // Opcodes 110 and 111 both have these two bits set.
  localparam logic [2:0] ALU_ILLEGAL_MASK = 3'b110;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic op_illegal(input logic [2:0] op);
    return (op & ALU_ILLEGAL_MASK) == ALU_ILLEGAL_MASK;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add, sub, and, or, logical and arithmetic right shift.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [Width-1:0] C
);

  localparam int unsigned ShW = $clog2(Width);

  logic [ShW-1:0] sh_amt;
  logic           sh_big;

  // The full B is the shift amount; anything at or past Width saturates.
  assign sh_amt = B[ShW-1:0];
  assign sh_big = |B[Width-1:ShW];

  always_comb begin
    C = '0;
    case (ALUOp)
      ALU_ADD: C = A + B;
      ALU_SUB: C = A - B;
      ALU_AND: C = A & B;
      ALU_OR:  C = A | B;
      ALU_SRL: C = sh_big ? '0 : (A >> sh_amt);
      ALU_SRA: C = sh_big ? {Width{A[Width-1]}} : $unsigned($signed(A) >>> sh_amt);
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU between two requesters, with a one-entry tagged
// result slot that drains and refills in the same cycle.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             prio_q, prio_d;

  logic             slot_free;
  logic             gnt_valid;
  logic             gnt_id;
  logic             accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [OPW-1:0]   sel_op;
  logic             sel_illegal;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_c;

  assign slot_free = !rsp_valid_q || rsp_ready;

  always_comb begin
    gnt_valid = req0_valid || req1_valid;
    gnt_id    = REQ0;
    if (req0_valid && req1_valid) begin
      gnt_id = prio_q;
    end else if (req1_valid) begin
      gnt_id = REQ1;
    end
  end

  assign accept     = gnt_valid && slot_free && !reset;
  assign req0_ready = accept && (gnt_id == REQ0);
  assign req1_ready = accept && (gnt_id == REQ1);

  assign sel_a  = (gnt_id == REQ1) ? req1_a : req0_a;
  assign sel_b  = (gnt_id == REQ1) ? req1_b : req0_b;
  assign sel_op = (gnt_id == REQ1) ? req1_op : req0_op;

  // Illegal opcodes run through the ALU as an add, but their result is forced to zero.
  assign sel_illegal = op_illegal(sel_op[2:0]);
  assign alu_op      = sel_illegal ? ALU_ADD : sel_op[2:0];

  alu #(
    .Width (WIDTH)
  ) u_alu (
    .A     (sel_a),
    .B     (sel_b),
    .ALUOp (alu_op),
    .C     (alu_c)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    prio_d      = prio_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_data_d  = sel_illegal ? '0 : alu_c;
      rsp_err_d   = sel_illegal;
      prio_d      = !gnt_id;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      prio_q      <= REQ0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      prio_q      <= prio_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
